// File: rtl/shift_seq_ctrl.sv
// Sequencer for an external 4-bit shift register: load a word, then issue
// COUNT shift/rotate steps, then capture the register's output.
//
// state   | meaning
// IDLE    | waiting for REQ, register disabled
// LOAD    | register loads D at the next edge
// SHIFT   | one shift/rotate per edge, down-counter tracks remaining steps
// FINISH  | register idle, Q captured into DATA_OUT on the leaving edge
module shift_seq_ctrl (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        REQ,
  input  logic [1:0]  OP,
  input  logic [3:0]  DATA_IN,
  input  logic [2:0]  COUNT,
  input  logic        FILL,
  input  logic [3:0]  Q,
  output logic [1:0]  MODO,
  output logic        DIR,
  output logic [3:0]  D,
  output logic        S_IN,
  output logic        ENB,
  output logic        BUSY,
  output logic        DONE,
  output logic [3:0]  DATA_OUT,
  output logic [15:0] SHIFT_TOTAL
);

  localparam logic [1:0] MODE_LOAD  = 2'b00;
  localparam logic [1:0] MODE_PUSH  = 2'b01;
  localparam logic [1:0] MODE_CYCLE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SHIFT  = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  op_r;
  logic        fill_r;
  logic [2:0]  cnt_r;

  logic [1:0]  modo_nxt;
  logic        dir_nxt;
  logic [3:0]  d_nxt;
  logic        s_in_nxt;
  logic        enb_nxt;
  logic        busy_nxt;
  logic        done_nxt;
  logic [3:0]  data_out_nxt;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= ST_IDLE;
      op_r        <= 2'b00;
      fill_r      <= 1'b0;
      cnt_r       <= 3'd0;
      MODO        <= MODE_LOAD;
      DIR         <= 1'b0;
      D           <= 4'd0;
      S_IN        <= 1'b0;
      ENB         <= 1'b0;
      BUSY        <= 1'b0;
      DONE        <= 1'b0;
      DATA_OUT    <= 4'd0;
      SHIFT_TOTAL <= 16'd0;
    end else begin
      state    <= state_nxt;
      MODO     <= modo_nxt;
      DIR      <= dir_nxt;
      D        <= d_nxt;
      S_IN     <= s_in_nxt;
      ENB      <= enb_nxt;
      BUSY     <= busy_nxt;
      DONE     <= done_nxt;
      DATA_OUT <= data_out_nxt;
      if (state == ST_IDLE && REQ) begin
        op_r   <= OP;
        fill_r <= FILL;
        cnt_r  <= COUNT;
      end else if (state == ST_SHIFT) begin
        cnt_r <= cnt_r - 3'd1;
      end
      if (state == ST_SHIFT && SHIFT_TOTAL != 16'hFFFF)
        SHIFT_TOTAL <= SHIFT_TOTAL + 16'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (REQ) state_nxt = ST_LOAD;
      ST_LOAD:   state_nxt = (cnt_r == 3'd0) ? ST_FINISH : ST_SHIFT;
      ST_SHIFT:  state_nxt = (cnt_r == 3'd1) ? ST_FINISH : ST_SHIFT;
      ST_FINISH: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state so the registered values
  // line up with the state they belong to.
  always_comb begin
    modo_nxt     = MODE_LOAD;
    dir_nxt      = 1'b0;
    d_nxt        = D;
    s_in_nxt     = 1'b0;
    enb_nxt      = 1'b0;
    busy_nxt     = (state_nxt != ST_IDLE);
    done_nxt     = (state == ST_FINISH);
    data_out_nxt = (state == ST_FINISH) ? Q : DATA_OUT;
    case (state_nxt)
      ST_LOAD: begin
        enb_nxt = 1'b1;
        d_nxt   = DATA_IN;
      end
      ST_SHIFT: begin
        enb_nxt  = 1'b1;
        modo_nxt = op_r[1] ? MODE_CYCLE : MODE_PUSH;
        dir_nxt  = op_r[0];
        s_in_nxt = op_r[1] ? 1'b0 : fill_r;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: behavioural 4-bit register attached to the
// controller, randomized operations, queue-based scoreboard on DONE.
module tb_shift_seq_ctrl;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        REQ = 1'b0;
  logic [1:0]  OP = 2'b00;
  logic [3:0]  DATA_IN = 4'd0;
  logic [2:0]  COUNT = 3'd0;
  logic        FILL = 1'b0;
  logic [3:0]  Q = 4'd0;
  logic [1:0]  MODO;
  logic        DIR;
  logic [3:0]  D;
  logic        S_IN;
  logic        ENB;
  logic        BUSY;
  logic        DONE;
  logic [3:0]  DATA_OUT;
  logic [15:0] SHIFT_TOTAL;

  shift_seq_ctrl dut (
    .CLK(CLK), .RESET(RESET), .REQ(REQ), .OP(OP), .DATA_IN(DATA_IN),
    .COUNT(COUNT), .FILL(FILL), .Q(Q), .MODO(MODO), .DIR(DIR), .D(D),
    .S_IN(S_IN), .ENB(ENB), .BUSY(BUSY), .DONE(DONE), .DATA_OUT(DATA_OUT),
    .SHIFT_TOTAL(SHIFT_TOTAL)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0]  dout;
    logic [15:0] total;
    int          done_cyc;
    int          edges;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   enb_run = 0;
  int   total_model = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // External register: 00 load, 01 shift with serial input, 10 rotate.
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (ENB) begin
      case (MODO)
        2'b00: Q <= D;
        2'b01: Q <= DIR ? {S_IN, Q[3:1]} : {Q[2:0], S_IN};
        2'b10: Q <= DIR ? {Q[0], Q[3:1]} : {Q[2:0], Q[3]};
        default: Q <= Q;
      endcase
    end
    if (RESET || DONE) enb_run <= 0;
    else if (ENB) enb_run <= enb_run + 1;
  end

  function automatic logic [3:0] model(input int op, input int v, input int n, input int f);
    int r;
    r = v;
    for (int i = 0; i < n; i++) begin
      case (op)
        0: r = (r * 2 + f) % 16;
        1: r = r / 2 + f * 8;
        2: r = (r * 2) % 16 + r / 8;
        default: r = r / 2 + (r % 2) * 8;
      endcase
    end
    return r[3:0];
  endfunction

  always @(negedge CLK) begin
    exp_t e;
    if (!RESET) begin
      check("enb_only_when_busy", 32'(ENB & ~BUSY), 32'd0);
      if (DONE) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got DONE=1 expected no pending op (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          check("done_cycle", 32'(cyc), 32'(e.done_cyc));
          check("data_out", 32'(DATA_OUT), 32'(e.dout));
          check("shift_total", 32'(SHIFT_TOTAL), 32'(e.total));
          check("enb_edges", 32'(enb_run), 32'(e.edges));
          check("busy_at_done", 32'(BUSY), 32'd0);
        end
      end else if (sb.size() > 0 && cyc > sb[0].done_cyc) begin
        e = sb.pop_front();
        checks++;
        errors++;
        $display("FAIL done_timeout: got no DONE expected at cycle %0d (now %0d)", e.done_cyc, cyc);
      end
    end
  end

  // Called at a negedge with the DUT idle at the next edge; returns at the
  // negedge of the DONE cycle. Inputs are scrambled while busy.
  task automatic issue(input logic [1:0] op, input logic [3:0] data, input logic [2:0] n,
                       input logic f, input bit hold);
    int   k;
    exp_t e;
    OP = op; DATA_IN = data; COUNT = n; FILL = f; REQ = 1'b1;
    k = cyc + 1;
    total_model = (total_model + int'(n) > 65535) ? 65535 : total_model + int'(n);
    e.dout = model(int'(op), int'(data), int'(n), int'(f));
    e.total = 16'(total_model);
    e.done_cyc = k + int'(n) + 2;
    e.edges = int'(n) + 1;
    sb.push_back(e);
    @(negedge CLK);
    check("busy_after_accept", 32'(BUSY), 32'd1);
    while (cyc < k + int'(n) + 2) begin
      OP = 2'($urandom); DATA_IN = 4'($urandom); COUNT = 3'($urandom); FILL = 1'($urandom);
      REQ = hold ? 1'b1 : 1'($urandom_range(0, 1));
      @(negedge CLK);
    end
    if (!hold) REQ = 1'b0;
  endtask

  initial begin
    int k;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_modo", 32'(MODO), 32'd0);
    check("rst_dir_sin_enb", 32'({DIR, S_IN, ENB}), 32'd0);
    check("rst_busy_done", 32'({BUSY, DONE}), 32'd0);
    check("rst_d_dout", 32'({D, DATA_OUT}), 32'd0);
    check("rst_total", 32'(SHIFT_TOTAL), 32'd0);
    RESET = 1'b0;

    issue(2'b00, 4'b1101, 3'd2, 1'b0, 1'b0);
    issue(2'b01, 4'b1101, 3'd1, 1'b1, 1'b0);
    issue(2'b11, 4'b0110, 3'd3, 1'b0, 1'b0);
    issue(2'b10, 4'b1010, 3'd1, 1'b0, 1'b0);
    issue(2'b00, 4'b1010, 3'd0, 1'b1, 1'b0);
    issue(2'b10, 4'b0011, 3'd4, 1'b1, 1'b1);
    issue(2'b01, 4'b1001, 3'd3, 1'b0, 1'b0);

    // Abort a COUNT=7 operation mid-shift, with REQ also high at the reset edge.
    OP = 2'b00; DATA_IN = 4'b1111; COUNT = 3'd7; FILL = 1'b0; REQ = 1'b1;
    k = cyc + 1;
    @(negedge CLK);
    REQ = 1'b0;
    repeat (3) @(negedge CLK);
    check("shift_total_mid", 32'(SHIFT_TOTAL), 32'(total_model + 2));
    RESET = 1'b1; REQ = 1'b1;
    @(posedge CLK);
    #1;
    sb.delete();
    total_model = 0;
    @(negedge CLK);
    check("abort_enb", 32'(ENB), 32'd0);
    check("abort_busy", 32'(BUSY), 32'd0);
    check("abort_done", 32'(DONE), 32'd0);
    check("abort_total", 32'(SHIFT_TOTAL), 32'd0);
    check("abort_dout", 32'(DATA_OUT), 32'd0);
    check("abort_cycle", 32'(cyc), 32'(k + 4));
    RESET = 1'b0;
    issue(2'b11, 4'b0001, 3'd2, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        REQ = 1'b0;
        @(negedge CLK);
      end
      issue(2'($urandom), 4'($urandom), 3'($urandom), 1'($urandom), 1'($urandom_range(0, 1)));
    end

    REQ = 1'b0;
    repeat (5) @(negedge CLK);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL pending_ops: got %0d outstanding expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
